inv_shiftrows_rx: RTL and testbench
===================================

INV_SHIFTROWS_RX -- requirements
Module: inv_shiftrows_rx

Interface
REQ-001 Parameter: INVERSE, default 1, 1 = InvShiftRows (receiver path), 0 = forward ShiftRows (loopback/self-test).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 flush  input  1  synchronous abort; discards any partially collected block.
REQ-005 in_valid  input  1  in_byte carries a valid byte.
REQ-006 in_ready  output  1  block can accept a byte this cycle.
REQ-007 in_byte  input  8  AES state byte; bytes arrive in state order 0..15.
REQ-008 out_valid  output  1  out_state holds a complete permuted block.
REQ-009 out_ready  input  1  downstream consumes out_state this cycle.
REQ-010 out_state  output  128 (bit order [0:127])  permuted state; byte k on bits [8k +: 8].

Function
REQ-011 State layout: column-major; byte k = row r + 4*col c, r,c in 0..3; first received byte is byte 0 (bits [0:7]).
REQ-012 INVERSE=1: out byte (r + 4c) = collected byte (r + 4*((c - r) mod 4)), i.e. row r rotated right by r.
REQ-013 INVERSE=0: out byte (r + 4c) = collected byte (r + 4*((c + r) mod 4)), i.e. row r rotated left by r.
REQ-014 Byte transfer occurs when in_valid && in_ready; output transfer occurs when out_valid && out_ready.
REQ-015 4-bit counter cnt holds number of bytes collected in the current block (0..15); each input transfer writes in_byte into collect buffer slot cnt and increments cnt.
REQ-016 in_ready = (cnt != 15) || !out_valid || out_ready; bytes 0..14 are never back-pressured.
REQ-017 Input transfer at cnt = 15: cnt wraps to 0; out_state loads permutation of {buffer bytes 0..14, in_byte}; out_valid = 1 next cycle (latency 1 cycle after 16th byte accepted).
REQ-018 Output transfer without a simultaneous 16th-byte transfer: out_valid = 0 next cycle; out_state holds last value.
REQ-019 Simultaneous output transfer and 16th-byte transfer: out_state reloads with new block, out_valid stays 1; no block lost or duplicated.
REQ-020 out_state and out_valid stable while out_valid && !out_ready.
REQ-021 Sustained throughput: one byte per cycle, one block per 16 cycles, with out_ready held high.
REQ-022 flush: cnt = 0 next cycle; any input transfer in the same cycle is ignored; out_valid/out_state unaffected.
REQ-023 flush while a completed block waits in out_state: that block is still delivered.
REQ-024 in_byte ignored when in_valid = 0; out_ready ignored when out_valid = 0.

Reset
REQ-025 rst_n low asynchronously forces cnt = 0, out_valid = 0, out_state = 128'h0, collect buffer = 0.
REQ-026 in_ready = 1 from the first cycle after reset deassertion.
REQ-027 Reset mid-block: partial block discarded; next accepted byte is byte 0 of a new block.

Verification
REQ-028 INVERSE=1, bytes 0x00..0x0F, out_ready=1 -> out_valid one cycle after 16th byte, out_state = 128'h000D0A0704010E0B0805020F0C090603.
REQ-029 INVERSE=0, bytes 0x00..0x0F -> out_state = 128'h00050A0F04090E03080D02070C01060B; chaining INVERSE=0 then INVERSE=1 returns input.
REQ-030 out_ready=0, first block complete, 15 bytes of second block sent -> in_ready=0 at cnt=15, out_state unchanged; raise out_ready -> 16th byte accepted same cycle, second block appears next cycle.
REQ-031 Two back-to-back blocks, in_valid and out_ready held high 32 cycles -> in_ready never low, two out_valid pulses 16 cycles apart.
REQ-032 flush after 7 bytes, then 16 bytes 0x00..0x0F -> output equals REQ-028 value.
REQ-033 rst_n pulsed low after 9 bytes and while out_valid=1 -> out_valid=0 and out_state=0 immediately; next 16 bytes produce correct block.

Source files
------------

// File: rtl/inv_shiftrows_rx.sv
// ---------------------------------------------------------------------------
// inv_shiftrows_rx
//
// Collects a 16-byte AES state one byte at a time (state order 0..15,
// column-major: byte k = row r + 4*col c) and presents the row-rotated block
// as a single 128-bit word.
//   INVERSE = 1 : InvShiftRows, row r rotated right by r (receiver path)
//   INVERSE = 0 : ShiftRows,    row r rotated left  by r (loopback/self-test)
//
// Ports
//   clk        in   1    rising-edge clock
//   rst_n      in   1    asynchronous active-low reset
//   flush      in   1    synchronous abort of the partially collected block
//   in_valid   in   1    in_byte carries a valid byte
//   in_ready   out  1    a byte can be accepted this cycle
//   in_byte    in   8    state byte, first byte of a block is byte 0
//   out_valid  out  1    out_state holds a complete permuted block
//   out_ready  in   1    downstream consumes out_state this cycle
//   out_state  out  128  permuted block, byte k on bits [8k +: 8] ([0:127])
// ---------------------------------------------------------------------------
module inv_shiftrows_rx #(
    parameter int unsigned INVERSE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_byte,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] out_state
);

    logic [3:0]   cnt;
    logic [0:119] coll;       // bytes 0..14 of the block being collected
    logic [0:127] full_blk;   // collected bytes plus the byte on the bus
    logic [0:127] perm_blk;
    logic         in_xfer;
    logic         last_xfer;
    logic         out_xfer;

    // Only the 16th byte needs a free output register; it may go through in
    // the same cycle the waiting block is consumed.
    assign in_ready  = (cnt != 4'd15) || !out_valid || out_ready;
    assign in_xfer   = in_valid && in_ready && !flush;
    assign last_xfer = in_xfer && (cnt == 4'd15);
    assign out_xfer  = out_valid && out_ready;

    // The 16th byte is never stored in coll; it is merged straight from the bus.
    assign full_blk  = {coll, in_byte};

    always_comb begin
        perm_blk = '0;
        for (int unsigned r = 0; r < 4; r++) begin
            for (int unsigned c = 0; c < 4; c++) begin
                int unsigned src_c;
                src_c = (INVERSE != 0) ? ((c + 4 - r) % 4) : ((c + r) % 4);
                perm_blk[8*(r + 4*c) +: 8] = full_blk[8*(r + 4*src_c) +: 8];
            end
        end
    end

    // Byte collection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            coll <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else if (in_xfer) begin
            if (cnt == 4'd15) begin
                cnt <= '0;
            end else begin
                coll[8*cnt +: 8] <= in_byte;
                cnt              <= cnt + 4'd1;
            end
        end
    end

    // Output register: a new block takes priority over consumption so that a
    // simultaneous load and take keeps out_valid high with the new data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_state <= '0;
        end else if (last_xfer) begin
            out_valid <= 1'b1;
            out_state <= perm_blk;
        end else if (out_xfer) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_inv_shiftrows_rx.sv
module tb_inv_shiftrows_rx;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic         in_valid;
    logic [7:0]   in_byte;
    logic         out_ready;
    logic         in_ready_i, out_valid_i;
    logic [0:127] out_state_i;
    logic         in_ready_f, out_valid_f;
    logic [0:127] out_state_f;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    inv_shiftrows_rx #(.INVERSE(1)) dut_inv (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_i), .in_byte(in_byte),
        .out_valid(out_valid_i), .out_ready(out_ready), .out_state(out_state_i)
    );

    inv_shiftrows_rx #(.INVERSE(0)) dut_fwd (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_f), .in_byte(in_byte),
        .out_valid(out_valid_f), .out_ready(out_ready), .out_state(out_state_f)
    );

    typedef struct {
        logic [0:127] blk;
        logic [0:127] exp_inv;
        logic [0:127] exp_fwd;
    } vec_t;

    vec_t tbl [4];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    // Reference: build the 4x4 matrix, rotate each row r by r places using a queue.
    function automatic logic [0:127] ref_perm(input logic [0:127] blk, input bit inv);
        logic [0:127] res;
        logic [7:0]   row [$];
        res = '0;
        for (int r = 0; r < 4; r++) begin
            row.delete();
            for (int c = 0; c < 4; c++) row.push_back(blk[8*(r + 4*c) +: 8]);
            for (int k = 0; k < r; k++) begin
                if (inv) row.push_front(row.pop_back());
                else     row.push_back(row.pop_front());
            end
            for (int c = 0; c < 4; c++) res[8*(r + 4*c) +: 8] = row[c];
        end
        return res;
    endfunction

    task automatic send_block(input logic [0:127] blk);
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_byte  = blk[8*i +: 8];
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic send_bytes(input logic [0:127] blk, input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_byte  = blk[8*i +: 8];
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [0:127] seq0, seq1;
        int ir_low, pulses, first_pulse, second_pulse;
        logic [7:0] q [$];
        logic         m_valid;
        logic [0:127] m_inv, m_fwd;
        logic         m_ready;
        logic [0:127] blk;

        tbl[0] = '{128'h000102030405060708090A0B0C0D0E0F,
                   128'h000D0A0704010E0B0805020F0C090603,
                   128'h00050A0F04090E03080D02070C01060B};
        tbl[1] = '{128'h101112131415161718191A1B1C1D1E1F,
                   128'h101D1A1714111E1B1815121F1C191613,
                   128'h10151A1F14191E13181D12171C11161B};
        tbl[2] = '{{16{8'hA5}}, {16{8'hA5}}, {16{8'hA5}}};
        tbl[3] = '{128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF,
                   128'hF0FDFAF7F4F1FEFBF8F5F2FFFCF9F6F3,
                   128'hF0F5FAFFF4F9FEF3F8FDF2F7FCF1F6FB};
        seq0 = tbl[0].blk;
        seq1 = tbl[1].blk;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_byte = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 128'(out_valid_i), 128'd0);
        chk("rst_out_state", out_state_i, 128'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 128'(in_ready_i), 128'd1);

        // Latency: nothing after 15 bytes, block one cycle after the 16th
        out_ready = 1'b1;
        send_bytes(seq0, 15);
        chk("lat_no_early_valid", 128'(out_valid_i), 128'd0);
        in_valid = 1'b1; in_byte = seq0[120 +: 8];
        @(negedge clk);
        in_valid = 1'b0;
        chk("lat_valid", 128'(out_valid_i), 128'd1);
        chk("lat_state", out_state_i, tbl[0].exp_inv);
        @(negedge clk);

        // Table-driven blocks on both instances
        for (int t = 0; t < 4; t++) begin
            send_block(tbl[t].blk);
            chk($sformatf("tbl%0d_valid", t), 128'(out_valid_i), 128'd1);
            chk($sformatf("tbl%0d_inv", t), out_state_i, tbl[t].exp_inv);
            chk($sformatf("tbl%0d_fwd", t), out_state_f, tbl[t].exp_fwd);
            chk($sformatf("tbl%0d_chain", t), ref_perm(out_state_f, 1'b1), tbl[t].blk);
            @(negedge clk);
            chk($sformatf("tbl%0d_consumed", t), 128'(out_valid_i), 128'd0);
            chk($sformatf("tbl%0d_hold", t), out_state_i, tbl[t].exp_inv);
        end

        // Back-pressure on the 16th byte only
        out_ready = 1'b0;
        send_block(seq0);
        send_bytes(seq1, 15);
        chk("bp_byte14_ok_valid", 128'(out_valid_i), 128'd1);
        in_valid = 1'b1; in_byte = seq1[120 +: 8];
        #1;
        chk("bp_in_ready_low", 128'(in_ready_i), 128'd0);
        repeat (2) @(negedge clk);
        chk("bp_state_held", out_state_i, tbl[0].exp_inv);
        chk("bp_valid_held", 128'(out_valid_i), 128'd1);
        out_ready = 1'b1;
        #1;
        chk("bp_in_ready_release", 128'(in_ready_i), 128'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_second_valid", 128'(out_valid_i), 128'd1);
        chk("bp_second_state", out_state_i, tbl[1].exp_inv);
        @(negedge clk);
        chk("bp_drained", 128'(out_valid_i), 128'd0);

        // Two back-to-back blocks, 32 cycles of streaming
        ir_low = 0; pulses = 0; first_pulse = -1; second_pulse = -1;
        for (int i = 0; i < 32; i++) begin
            in_valid = 1'b1; in_byte = 8'(i);
            #1;
            if (!in_ready_i) ir_low++;
            @(negedge clk);
            if (out_valid_i) begin
                pulses++;
                if (first_pulse < 0) first_pulse = i; else second_pulse = i;
                if (i == 31) chk("b2b_second_state", out_state_i, tbl[1].exp_inv);
            end
        end
        in_valid = 1'b0;
        chk("b2b_in_ready_low_count", 128'(ir_low), 128'd0);
        chk("b2b_pulses", 128'(pulses), 128'd2);
        chk("b2b_spacing", 128'(second_pulse - first_pulse), 128'd16);
        @(negedge clk);

        // Flush after 7 bytes, flush-cycle byte ignored
        send_bytes(seq1, 7);
        flush = 1'b1; in_valid = 1'b1; in_byte = 8'hEE;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        send_block(seq0);
        chk("flush_valid", 128'(out_valid_i), 128'd1);
        chk("flush_state", out_state_i, tbl[0].exp_inv);
        @(negedge clk);

        // Flush while a block waits: block survives, collection restarts
        out_ready = 1'b0;
        send_block(seq1);
        flush = 1'b1; in_valid = 1'b1; in_byte = 8'h77;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        chk("flushw_valid", 128'(out_valid_i), 128'd1);
        chk("flushw_state", out_state_i, tbl[1].exp_inv);
        send_bytes(seq0, 15);
        in_valid = 1'b1; in_byte = seq0[120 +: 8];
        #1;
        chk("flushw_cnt15_stall", 128'(in_ready_i), 128'd0);
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("flushw_next_state", out_state_i, tbl[0].exp_inv);
        @(negedge clk);

        // Reset mid-block while a block is waiting
        out_ready = 1'b0;
        send_block(seq1);
        send_bytes(seq0, 9);
        chk("rstmid_pre_valid", 128'(out_valid_i), 128'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_valid", 128'(out_valid_i), 128'd0);
        chk("rstmid_state", out_state_i, 128'd0);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        send_block(seq0);
        chk("rstmid_next_valid", 128'(out_valid_i), 128'd1);
        chk("rstmid_next_state", out_state_i, tbl[0].exp_inv);
        @(negedge clk);

        // Randomized traffic against the queue-based reference
        do_reset();
        q.delete(); m_valid = 1'b0; m_inv = '0; m_fwd = '0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_byte   = 8'($urandom);
            out_ready = ($urandom_range(0, 1) != 0);
            flush     = ($urandom_range(0, 59) == 0);
            m_ready   = (q.size() != 15) || !m_valid || out_ready;
            #1;
            chk("rnd_in_ready", 128'(in_ready_i), 128'(m_ready));
            if (flush) begin
                q.delete();
                if (m_valid && out_ready) m_valid = 1'b0;
            end else begin
                if (m_valid && out_ready) m_valid = 1'b0;
                if (in_valid && m_ready) begin
                    q.push_back(in_byte);
                    if (q.size() == 16) begin
                        for (int k = 0; k < 16; k++) blk[8*k +: 8] = q[k];
                        m_inv = ref_perm(blk, 1'b1);
                        m_fwd = ref_perm(blk, 1'b0);
                        m_valid = 1'b1;
                        q.delete();
                    end
                end
            end
            @(negedge clk);
            chk("rnd_out_valid", 128'(out_valid_i), 128'(m_valid));
            chk("rnd_state_inv", out_state_i, m_inv);
            chk("rnd_state_fwd", out_state_f, m_fwd);
        end
        in_valid = 1'b0; flush = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
